cpu_write_queue: RTL

Command queue and four-phase handshake driver that sits directly upstream of the CPU-bus board's write port (`shouldWrite`/`writeDone`/`writeAddress`/`writeData`). A host-side source pushes 16-bit address/data write commands at any rate. The block buffers them in a FIFO and replays them one at a time, each with a fully completed request/acknowledge cycle. It enforces a minimum idle gap between writes and aborts writes that are never acknowledged, so a stalled CPU mock cannot hang the host.

---
 rtl/cpu_write_queue_if.sv | 32 +++
 rtl/cpu_write_queue.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cpu_write_queue_if.sv
// Host command port and CPU-mock write handshake bundled for cpu_write_queue.
// slave: the queue itself; master: the host/mock side driving commands and acks.
interface cpu_write_queue_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          CMD_VALID_IN;
  logic          CMD_READY_OUT;
  logic [15:0]   CMD_ADDR_IN;
  logic [15:0]   CMD_DATA_IN;
  logic          shouldWrite;
  logic          writeDone;
  logic [15:0]   writeAddress;
  logic [15:0]   writeData;
  logic [LW-1:0] LEVEL_OUT;
  logic          BUSY_OUT;
  logic          TIMEOUT_ERR_OUT;
  logic          ERR_CLR_IN;

  modport master (
    output CMD_VALID_IN, CMD_ADDR_IN, CMD_DATA_IN, writeDone, ERR_CLR_IN,
    input  CMD_READY_OUT, shouldWrite, writeAddress, writeData,
           LEVEL_OUT, BUSY_OUT, TIMEOUT_ERR_OUT
  );

  modport slave (
    input  CMD_VALID_IN, CMD_ADDR_IN, CMD_DATA_IN, writeDone, ERR_CLR_IN,
    output CMD_READY_OUT, shouldWrite, writeAddress, writeData,
           LEVEL_OUT, BUSY_OUT, TIMEOUT_ERR_OUT
  );
endinterface

// File: rtl/cpu_write_queue.sv
// Buffers host write commands and replays each one to the CPU mock as a full
// four-phase shouldWrite/writeDone handshake, with an idle gap and a stall timeout.
module cpu_write_queue #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             XTAL_IN,
  input  logic             RESET_IN,
  cpu_write_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
  // A timeout abort always passes through GAP for at least one cycle.
  localparam logic [GW-1:0] GAP_MIN  = (GAP_CYCLES == 0) ? GW'(1) : GW'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, ACK, GAP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          should_write_q, should_write_d;
  logic [15:0]   addr_q, addr_d, data_q, data_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   head;
  logic          cmd_ready, push, pop, err_set;

  assign cmd_ready = (level_q != LW'(DEPTH));
  assign push      = bus.CMD_VALID_IN & cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge XTAL_IN) begin
    if (push) mem_q[wr_ptr_q] <= {bus.CMD_ADDR_IN, bus.CMD_DATA_IN};
  end

  always_comb begin
    state_d        = state_q;
    should_write_d = should_write_q;
    addr_d         = addr_q;
    data_d         = data_q;
    to_cnt_d       = to_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    pop            = 1'b0;
    err_set        = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          addr_d         = head[31:16];
          data_d         = head[15:0];
          should_write_d = 1'b1;
          to_cnt_d       = '0;
          state_d        = REQ;
        end
      end
      REQ: begin
        if (bus.writeDone) begin
          should_write_d = 1'b0;
          pop            = 1'b1;
          state_d        = ACK;
        end else if (TIMEOUT_CYCLES != 0 && to_cnt_q == TO_LAST) begin
          should_write_d = 1'b0;
          pop            = 1'b1;
          err_set        = 1'b1;
          gap_cnt_d      = GAP_MIN;
          state_d        = GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ACK: begin
        if (!bus.writeDone) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = GAP_LOAD;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q <= GW'(1)) state_d = IDLE;
        else                     gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    // An abort on the same edge as a clear must leave the flag set.
    if (err_set)             err_d = 1'b1;
    else if (bus.ERR_CLR_IN) err_d = 1'b0;
    else                     err_d = err_q;
  end

  always_ff @(posedge XTAL_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      should_write_q <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      to_cnt_q       <= '0;
      gap_cnt_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      should_write_q <= should_write_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      to_cnt_q       <= to_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      err_q          <= err_d;
    end
  end

  assign bus.CMD_READY_OUT   = cmd_ready;
  assign bus.shouldWrite     = should_write_q;
  assign bus.writeAddress    = addr_q;
  assign bus.writeData       = data_q;
  assign bus.LEVEL_OUT       = level_q;
  assign bus.BUSY_OUT        = (state_q != IDLE) | (level_q != '0);
  assign bus.TIMEOUT_ERR_OUT = err_q;
endmodule
